uart_tx_fifo: RTL and testbench

- Transmit buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the register/APB write side and stores them in a DEPTH-entry FIFO.
- Hands one byte at a time to the transmitter as data_o plus a single-cycle start_tx_o pulse.
- Waits for the transmitter's trans_fi_i completion pulse before issuing the next byte.

---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit buffer placed directly upstream of the UART transmitter.
// Bytes written on the register side are queued in a DEPTH-entry FIFO.
// One byte at a time is handed to the transmitter as data_o together with
// a single-cycle start_tx_o pulse. The next byte is not launched until the
// transmitter reports completion on trans_fi_i.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   wr_en_i, wr_data_i        write strobe and byte to enqueue
//   flush_i                   synchronous FIFO clear (pointers and count)
//   tx_en_i                   gates new frame launches only
//   trans_fi_i                transmitter frame-finished pulse
//   clr_ovf_i                 clears the sticky overflow flag
//   data_o, start_tx_o        byte and launch pulse to the transmitter
//   full_o, empty_o, count_o  FIFO occupancy
//   busy_o                    a frame is being launched or is in flight
//   tx_done_o                 one-cycle pulse after a frame completes
//   overflow_o                sticky: a write was dropped because full
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  flush_i,
  input  logic                  tx_en_i,
  input  logic                  trans_fi_i,
  input  logic                  clr_ovf_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  start_tx_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  busy_o,
  output logic                  tx_done_o,
  output logic                  overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_done_q, tx_done_d;
  logic                  ovf_q, ovf_d;

  logic full, empty, wr_accept, pop;

  // Occupancy decisions use the pre-edge count, so a pop in the same cycle
  // never makes room for a write. Flush overrides both write and pop.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en_i && !full && !flush_i;
  assign pop       = (state_q == ST_IDLE) && tx_en_i && !empty && !flush_i;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    tx_done_d = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (trans_fi_i) begin
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    if (pop) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Set has priority over clear so a drop in the clearing cycle is kept.
    if (wr_en_i && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= '0;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      tx_done_q <= tx_done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage has no reset so it can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign data_o     = data_q;
  assign start_tx_o = (state_q == ST_START);
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_done_o  = tx_done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Stimulus is directed; expected
// bytes are pushed into a scoreboard queue when the bench knows a write is
// accepted, and a monitor compares data_o on every start_tx_o pulse.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en_i, flush_i, tx_en_i, trans_fi_i, clr_ovf_i;
  logic [7:0] wr_data_i;
  logic [7:0] data_o;
  logic       start_tx_o, full_o, empty_o, busy_o, tx_done_o, overflow_o;
  logic [4:0] count_o;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  int dones = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .flush_i(flush_i),
    .tx_en_i(tx_en_i), .trans_fi_i(trans_fi_i), .clr_ovf_i(clr_ovf_i),
    .data_o(data_o), .start_tx_o(start_tx_o), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o),
    .tx_done_o(tx_done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each launch must carry the oldest expected byte.
  always @(negedge clk) begin
    if (start_tx_o === 1'b1) begin
      starts++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: got data %0h, expected no launch", data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("frame_data", {24'd0, data_o}, {24'd0, e});
        $display("[TB] frame launched data=%02h", data_o);
      end
    end
    if (tx_done_o === 1'b1) dones++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Must be called while the DUT is in WAIT.
  task automatic finish_frame();
    trans_fi_i = 1'b1;
    step();
    trans_fi_i = 1'b0;
  endtask

  // Finish current frame, then pop and move to WAIT on the next byte.
  task automatic frame_cycle();
    finish_frame();
    step();
    step();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_accept);
    wr_en_i = 1'b1;
    wr_data_i = d;
    if (expect_accept) exp_q.push_back(d);
    step();
    wr_en_i = 1'b0;
  endtask

  initial begin
    int s0, d0, writes, m_cnt, cyc;
    int m_st;  // 0 idle, 1 start, 2 wait
    bit wr, tf, acc, pp;
    logic [7:0] wd;

    reset_n = 1'b0;
    wr_en_i = 0; flush_i = 0; tx_en_i = 0; trans_fi_i = 0; clr_ovf_i = 0;
    wr_data_i = 8'h00;
    repeat (3) step();

    // ---- Reset values
    chk("rst_data", {24'd0, data_o}, 32'h0);
    chk("rst_start", {31'd0, start_tx_o}, 32'h0);
    chk("rst_count", {27'd0, count_o}, 32'h0);
    chk("rst_empty", {31'd0, empty_o}, 32'h1);
    chk("rst_full", {31'd0, full_o}, 32'h0);
    chk("rst_busy", {31'd0, busy_o}, 32'h0);
    chk("rst_done", {31'd0, tx_done_o}, 32'h0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'h0);
    reset_n = 1'b1;
    step();

    // ---- Test 1: single byte latency
    tx_en_i = 1'b1;
    write_byte(8'hA5, 1);
    chk("t1_count_after_e0", {27'd0, count_o}, 32'd1);
    chk("t1_busy_after_e0", {31'd0, busy_o}, 32'h0);
    step();
    chk("t1_count_after_e1", {27'd0, count_o}, 32'd0);
    chk("t1_data_after_e1", {24'd0, data_o}, 32'hA5);
    chk("t1_start", {31'd0, start_tx_o}, 32'h1);
    step();
    chk("t1_start_one_cycle", {31'd0, start_tx_o}, 32'h0);
    repeat (3) step();
    chk("t1_busy_wait", {31'd0, busy_o}, 32'h1);
    d0 = dones;
    finish_frame();
    chk("t1_busy_idle", {31'd0, busy_o}, 32'h0);
    chk("t1_done", {31'd0, tx_done_o}, 32'h1);
    step();
    chk("t1_done_pulse", {31'd0, tx_done_o}, 32'h0);
    chk("t1_starts", starts, 32'd1);
    chk("t1_dones", dones - d0, 32'd1);

    // ---- Test 2: fill, overflow, drain in order
    tx_en_i = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1);
    write_byte(8'hFF, 0);
    chk("t2_full", {31'd0, full_o}, 32'h1);
    chk("t2_count", {27'd0, count_o}, 32'd16);
    chk("t2_ovf", {31'd0, overflow_o}, 32'h1);
    s0 = starts;
    d0 = dones;
    tx_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (20) step();
      finish_frame();
    end
    step();
    chk("t2_starts", starts - s0, 32'd16);
    chk("t2_dones", dones - d0, 32'd16);
    chk("t2_empty", {31'd0, empty_o}, 32'h1);
    chk("t2_queue_drained", exp_q.size(), 32'd0);
    chk("t2_ovf_sticky", {31'd0, overflow_o}, 32'h1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("t2_ovf_clr", {31'd0, overflow_o}, 32'h0);

    // ---- Test 3: write in the pop cycle while full is dropped
    tx_en_i = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i), 1);
    tx_en_i = 1'b1;
    write_byte(8'hEE, 0);
    chk("t3_count", {27'd0, count_o}, 32'd15);
    chk("t3_ovf", {31'd0, overflow_o}, 32'h1);
    chk("t3_full", {31'd0, full_o}, 32'h0);
    chk("t3_start", {31'd0, start_tx_o}, 32'h1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("t3_ovf_clr", {31'd0, overflow_o}, 32'h0);
    for (int i = 0; i < 12; i++) frame_cycle();
    chk("t3_count_left", {27'd0, count_o}, 32'd3);
    chk("t3_busy", {31'd0, busy_o}, 32'h1);

    // ---- Test 4: tx_en dropped in WAIT
    tx_en_i = 1'b0;
    s0 = starts;
    repeat (2) step();
    finish_frame();
    chk("t4_done", {31'd0, tx_done_o}, 32'h1);
    repeat (5) step();
    chk("t4_no_start", starts - s0, 32'd0);
    chk("t4_busy", {31'd0, busy_o}, 32'h0);
    chk("t4_count", {27'd0, count_o}, 32'd3);
    tx_en_i = 1'b1;
    step();
    chk("t4_start", {31'd0, start_tx_o}, 32'h1);
    chk("t4_data", {24'd0, data_o}, 32'h1D);
    chk("t4_count_pop", {27'd0, count_o}, 32'd2);
    step();
    frame_cycle();
    frame_cycle();
    finish_frame();
    step();
    chk("t4_empty", {31'd0, empty_o}, 32'h1);

    // ---- Test 5: interleaved traffic with pointer wrap, count model
    writes = 0; m_cnt = 0; m_st = 0; cyc = 0;
    while (!(writes == 40 && m_cnt == 0 && m_st == 0) && cyc < 3000) begin
      wr = (writes < 40) && ($urandom_range(0, 2) != 0);
      wd = 8'($urandom_range(0, 255));
      tf = (m_st == 2) && ($urandom_range(0, 3) == 0);
      acc = wr && (m_cnt != 16);
      pp = (m_st == 0) && (m_cnt != 0);
      if (acc) begin
        exp_q.push_back(wd);
        writes++;
      end
      m_cnt = m_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      case (m_st)
        0: if (pp) m_st = 1;
        1: m_st = 2;
        default: if (tf) m_st = 0;
      endcase
      wr_en_i = wr; wr_data_i = wd; trans_fi_i = tf;
      step();
      wr_en_i = 1'b0; trans_fi_i = 1'b0;
      chk("t5_count", {27'd0, count_o}, 32'(m_cnt));
      chk("t5_busy", {31'd0, busy_o}, {31'd0, m_st != 0});
      cyc++;
    end
    chk("t5_terminated", {31'd0, cyc < 3000}, 32'h1);
    step();
    chk("t5_queue_drained", exp_q.size(), 32'd0);

    // ---- Test 6: flush mid-frame, then reset mid-frame
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("t6_ovf_clr", {31'd0, overflow_o}, 32'h0);
    tx_en_i = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i), 1);
    tx_en_i = 1'b1;
    step();
    tx_en_i = 1'b0;
    step();
    chk("t6_count_before", {27'd0, count_o}, 32'd5);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    exp_q.delete();
    chk("t6_flush_count", {27'd0, count_o}, 32'd0);
    chk("t6_flush_empty", {31'd0, empty_o}, 32'h1);
    chk("t6_flush_busy", {31'd0, busy_o}, 32'h1);
    finish_frame();
    chk("t6_flush_done", {31'd0, tx_done_o}, 32'h1);
    chk("t6_data_kept", {24'd0, data_o}, 32'hA0);
    step();
    tx_en_i = 1'b1;
    write_byte(8'hB0, 1);
    step();
    step();
    chk("t6_busy_wait", {31'd0, busy_o}, 32'h1);
    d0 = dones;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_data", {24'd0, data_o}, 32'h0);
    chk("t6_rst_busy", {31'd0, busy_o}, 32'h0);
    chk("t6_rst_count", {27'd0, count_o}, 32'd0);
    chk("t6_rst_empty", {31'd0, empty_o}, 32'h1);
    chk("t6_rst_start", {31'd0, start_tx_o}, 32'h0);
    chk("t6_rst_ovf", {31'd0, overflow_o}, 32'h0);
    tx_en_i = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("t6_no_done", dones - d0, 32'd0);
    chk("t6_idle", {31'd0, busy_o}, 32'h0);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
